// File: rtl/if_id_stage.sv
// PC register plus IF/ID pipeline register. It applies hazard-unit holds and inserts one bubble on a taken branch or jump.
// With IF_ID_STALL_CNT_EN defined, stall_cycles is a saturating count of PC-hold edges; otherwise it is tied to zero.
`timescale 1ns/1ps
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        IF_ID_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_pc4,
    output logic        ID_valid,
    output logic [15:0] stall_cycles
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic [31:0] w_pc4;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    assign w_pc4      = r_pc + 32'd4;
    assign w_redirect = branch_taken | jump;
    // jump beats branch_taken if decode ever raises both
    assign w_redirect_pc = (jump ? jump_target : branch_target) & WORD_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC & WORD_MASK;
        end else if (!pc_write) begin
            r_pc <= w_redirect ? w_redirect_pc : w_pc4;
        end
    end

    // A hold outranks a redirect: the branch in ID is still waiting on operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_instr <= NOP_INSTR;
            r_id_pc4   <= 32'd0;
            r_id_valid <= 1'b0;
        end else if (!IF_ID_write) begin
            if (w_redirect) begin
                r_id_instr <= NOP_INSTR;
                r_id_pc4   <= 32'd0;
                r_id_valid <= 1'b0;
            end else begin
                r_id_instr <= imem_instr;
                r_id_pc4   <= w_pc4;
                r_id_valid <= 1'b1;
            end
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (pc_write && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 16'h0000;
`endif

    assign imem_addr = r_pc;
    assign ID_instr  = r_id_instr;
    assign ID_pc4    = r_id_pc4;
    assign ID_valid  = r_id_valid;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard testbench for if_id_stage. A spec-level model pushes the expected state on each edge,
// and each scenario task pops and compares it after the edge. It also compares fixed addresses from the test plan.
`timescale 1ns/1ps
module tb_if_id_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0;
    logic        IF_ID_write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] ID_instr;
    logic [31:0] ID_pc4;
    logic        ID_valid;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    obs_t sb[$];
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pc4 = 32'd0;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    logic        fixed_mode = 1'b0;
    logic [31:0] fixed_word = 32'h2008_0005;

    if_id_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_instr(imem_instr),
        .imem_addr(imem_addr), .ID_instr(ID_instr), .ID_pc4(ID_pc4),
        .ID_valid(ID_valid), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return fixed_mode ? fixed_word : ((a ^ 32'h5A5A_0000) | 32'h1);
    endfunction

    assign imem_instr = mem(imem_addr);

    function automatic obs_t observe();
        return {imem_addr, ID_instr, ID_pc4, ID_valid, stall_cycles};
    endfunction

    // Model the edge from the current inputs, push the expectation, then advance past the edge.
    task automatic step();
        obs_t e;
        if (rst) begin
            m_pc = RST_PC; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 16'd0;
        end else begin
            if (!IF_ID_write) begin
                if (jump || branch_taken) begin
                    m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
                end else begin
                    m_instr = mem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                end
            end
            if (!pc_write)
                m_pc = jump ? (jump_target & 32'hFFFF_FFFC)
                     : branch_taken ? (branch_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
`ifdef IF_ID_STALL_CNT_EN
            else if (m_cnt != 16'hFFFF)
                m_cnt = m_cnt + 16'd1;
`endif
        end
        e = {m_pc, m_instr, m_pc4, m_valid, m_cnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        pc_write = 0; IF_ID_write = 0; branch_taken = 0; jump = 0; rst = 0;
    endtask

    task automatic test_reset();
        obs_t got, e;
        rst = 1'b1;
        step();
        got = observe(); e = sb.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset: got %h required %h", got, e);
        end
        checks++;
        if (imem_addr !== 32'h3000 || ID_valid !== 1'b0 || stall_cycles !== 16'h0) begin
            errors++;
            $display("FAIL reset_const: addr=%h valid=%b cnt=%h required 3000/0/0", imem_addr, ID_valid, stall_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        obs_t got, e;
        fixed_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL free_run[%0d]: got %h required %h", i, got, e);
            end
            if (i == 0) begin
                checks++;
                if (imem_addr !== 32'h3004 || ID_instr !== 32'h2008_0005 || ID_pc4 !== 32'h3004 || ID_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL free_run_const: addr=%h instr=%h pc4=%h valid=%b", imem_addr, ID_instr, ID_pc4, ID_valid);
                end
            end
        end
        fixed_mode = 1'b0;
    endtask

    task automatic test_stall();
        obs_t got, e;
        for (int i = 0; i < 3; i++) begin
            pc_write = (i == 0); IF_ID_write = (i == 0);
            step();
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stall[%0d]: got %h required %h", i, got, e);
            end
        end
        checks++;
`ifdef IF_ID_STALL_CNT_EN
        if (stall_cycles !== 16'd1) begin
`else
        if (stall_cycles !== 16'd0) begin
`endif
            errors++;
            $display("FAIL stall_count: got %h", stall_cycles);
        end
        clear_ctl();
    endtask

    task automatic test_branch();
        obs_t got, e;
        for (int i = 0; i < 4; i++) begin
            branch_taken = (i == 0) || (i == 2);
            branch_target = (i == 0) ? 32'h3040 : 32'h3203;
            step();
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL branch[%0d]: got %h required %h", i, got, e);
            end
            if (i == 0) begin
                checks++;
                if (imem_addr !== 32'h3040 || ID_valid !== 1'b0 || ID_instr !== NOP) begin
                    errors++;
                    $display("FAIL branch_redirect: addr=%h valid=%b instr=%h", imem_addr, ID_valid, ID_instr);
                end
            end
            if (i == 1) begin
                checks++;
                if (ID_pc4 !== 32'h3044 || ID_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL branch_target_id: pc4=%h valid=%b required 3044/1", ID_pc4, ID_valid);
                end
            end
            if (i == 2) begin
                checks++;
                if (imem_addr !== 32'h3200) begin
                    errors++;
                    $display("FAIL branch_align: addr=%h required 3200", imem_addr);
                end
            end
        end
        clear_ctl();
    endtask

    task automatic test_stall_branch();
        obs_t got, e;
        logic [31:0] held_pc;
        held_pc = imem_addr;
        branch_target = 32'h3080;
        for (int i = 0; i < 3; i++) begin
            pc_write = (i == 0); IF_ID_write = (i == 0); branch_taken = (i < 2);
            step();
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stall_branch[%0d]: got %h required %h", i, got, e);
            end
            if (i == 0) begin
                checks++;
                if (imem_addr !== held_pc) begin
                    errors++;
                    $display("FAIL stall_branch_hold: addr=%h required %h", imem_addr, held_pc);
                end
            end
            if (i == 1) begin
                checks++;
                if (imem_addr !== 32'h3080 || ID_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_branch_release: addr=%h valid=%b", imem_addr, ID_valid);
                end
            end
        end
        clear_ctl();
    endtask

    task automatic test_jump_tie();
        obs_t got, e;
        jump_target = 32'h3100; branch_target = 32'h3200;
        for (int i = 0; i < 2; i++) begin
            jump = (i == 0); branch_taken = (i == 0);
            step();
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL jump_tie[%0d]: got %h required %h", i, got, e);
            end
            if (i == 0) begin
                checks++;
                if (imem_addr !== 32'h3100) begin
                    errors++;
                    $display("FAIL jump_wins: addr=%h required 3100", imem_addr);
                end
            end
        end
        clear_ctl();
    endtask

    task automatic test_split_hold();
        obs_t got, e;
        // PC held with IF/ID loading twice, then PC advancing while IF/ID holds.
        for (int i = 0; i < 5; i++) begin
            pc_write    = (i < 2);
            IF_ID_write = (i == 2) || (i == 3);
            step();
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL split_hold[%0d]: got %h required %h", i, got, e);
            end
        end
        clear_ctl();
    endtask

    task automatic test_wrap();
        obs_t got, e;
        jump_target = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            jump = (i == 0);
            step();
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h required %h", i, got, e);
            end
            if (i == 1) begin
                checks++;
                if (imem_addr !== 32'h0 || ID_pc4 !== 32'h0 || ID_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_zero: addr=%h pc4=%h valid=%b", imem_addr, ID_pc4, ID_valid);
                end
            end
        end
        clear_ctl();
    endtask

    task automatic test_reset_mid_stall();
        obs_t got, e;
        branch_target = 32'h3400;
        for (int i = 0; i < 4; i++) begin
            pc_write = 1'b1; IF_ID_write = 1'b1; branch_taken = (i == 2);
            rst = (i == 2);
            if (i == 3) begin
                pc_write = 1'b0; IF_ID_write = 1'b0;
            end
            step();
            got = observe(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_stall[%0d]: got %h required %h", i, got, e);
            end
            if (i == 2) begin
                checks++;
                if (imem_addr !== 32'h3000 || ID_valid !== 1'b0 || stall_cycles !== 16'h0) begin
                    errors++;
                    $display("FAIL reset_wins: addr=%h valid=%b cnt=%h", imem_addr, ID_valid, stall_cycles);
                end
            end
        end
        clear_ctl();
    endtask

`ifdef IF_ID_STALL_CNT_EN
    task automatic test_saturate();
        obs_t got, e;
        pc_write = 1'b1; IF_ID_write = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        repeat (69999) void'(sb.pop_front());
        got = observe(); e = sb.pop_front(); checks++;
        if (got !== e || stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate: got %h required %h cnt=%h", got, e, stall_cycles);
        end
        clear_ctl();
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_stall_branch();
        test_jump_tie();
        test_split_hold();
        test_wrap();
        test_reset_mid_stall();
`ifdef IF_ID_STALL_CNT_EN
        test_saturate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
